onehot_stream_encoder: RTL and testbench

ONEHOT_STREAM_ENCODER -- requirements
Module: onehot_stream_encoder

---
 rtl/encoder_pkg.sv | 22 ++
 rtl/onehot_stream_encoder_priority_find4.sv | 36 +++
 rtl/onehot_stream_encoder.sv | 125 ++++++++++++
 tb/tb_onehot_stream_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the one-hot stream encoder.
//   - DATA_W / CODE_W : request word width and code (index) width
//   - state_e         : encoder FSM states
//   - index_to_mask() : turns a code back into the single-bit mask it names
package encoder_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Single-bit mask with bit <idx> set, used to retire an emitted request.
  function automatic logic [DATA_W-1:0] index_to_mask(input logic [CODE_W-1:0] idx);
    logic [DATA_W-1:0] one;
    one = DATA_W'(1);
    index_to_mask = one << idx;
  endfunction

endpackage

// File: rtl/onehot_stream_encoder_priority_find4.sv
// priority_find4: combinational bit selector for the encoder.
// Ports:
//   mask      (in)  : pending request bits
//   lsb_first (in)  : 1 = pick lowest set index, 0 = pick highest
//   index     (out) : selected bit index (0 when mask is empty)
//   single    (out) : mask has exactly one bit set
module priority_find4
  import encoder_pkg::*;
(
  input  logic [DATA_W-1:0] mask,
  input  logic              lsb_first,
  output logic [CODE_W-1:0] index,
  output logic              single
);

  // Scan order makes the last match win: descending scan leaves the lowest
  // set bit, ascending scan leaves the highest.
  always_comb begin
    index = '0;
    if (lsb_first) begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        index = mask[i] ? CODE_W'(i) : index;
      end
    end else begin
      for (int i = 0; i < DATA_W; i++) begin
        index = mask[i] ? CODE_W'(i) : index;
      end
    end
  end

  // Exactly one bit set: non-empty and clearing the lowest bit empties it.
  always_comb begin
    single = (mask != '0) && ((mask & (mask - DATA_W'(1))) == '0);
  end

endmodule

// File: rtl/onehot_stream_encoder.sv
// onehot_stream_encoder: takes a multi-hot request word and streams out the
// index of every set bit, one beat per bit, with valid/ready handshakes on
// both sides.
// Parameter:
//   LSB_FIRST : 1 = ascending index order, 0 = descending
// Ports:
//   clk, rst (sync, active-high)
//   en                 : acceptance enable (an in-progress word still finishes)
//   in_valid/in_ready/D: input word handshake
//   out_valid/out_ready: output beat handshake
//   Y                  : index of the current set bit
//   last               : current beat is the final one of its word
//   zero               : current beat reports an all-zero word
// Build option:
//   ONEHOT_STREAM_ENCODER_ZERO_FLAG_EN - when defined, an all-zero word
//   produces one beat with zero=1; otherwise it is consumed silently.
module onehot_stream_encoder
  import encoder_pkg::*;
#(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] Y,
  output logic              last,
  output logic              zero
);

`ifdef ONEHOT_STREAM_ENCODER_ZERO_FLAG_EN
  localparam bit ZERO_FLAG = 1'b1;
`else
  localparam bit ZERO_FLAG = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pending_q, pending_d;

  logic [CODE_W-1:0] sel_idx_s;
  logic              sel_single_s;
  logic              cur_valid_s;
  logic              zero_word_s;
  logic              cur_last_s;
  logic              fire_s;
  logic              done_s;
  logic              in_ready_s;
  logic              accept_s;

  priority_find4 u_find (
    .mask      (pending_q),
    .lsb_first (LSB_FIRST != 0),
    .index     (sel_idx_s),
    .single    (sel_single_s)
  );

  // Handshake terms; everything the outputs see comes from state_q/pending_q.
  always_comb begin
    cur_valid_s = (state_q == EMIT);
    // An empty mask while emitting only happens for a flagged zero word.
    zero_word_s = ZERO_FLAG && (pending_q == '0);
    cur_last_s  = sel_single_s || zero_word_s;
    fire_s      = cur_valid_s && out_ready;
    done_s      = fire_s && cur_last_s;
    in_ready_s  = en && !rst && ((state_q == IDLE) || done_s);
    accept_s    = in_valid && in_ready_s;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic: retire emitted bits, then let a new word take over.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        state_d   = IDLE;
        pending_d = pending_q;
      end
      EMIT: begin
        if (fire_s) begin
          pending_d = pending_q & ~index_to_mask(sel_idx_s);
          state_d   = cur_last_s ? IDLE : EMIT;
        end else begin
          state_d   = EMIT;
          pending_d = pending_q;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
    // A same-cycle accept on the final beat gives back-to-back words.
    if (accept_s) begin
      pending_d = D;
      state_d   = (ZERO_FLAG || (D != '0)) ? EMIT : IDLE;
    end else begin
      pending_d = pending_d;
    end
  end

  // Output logic: all beat fields are forced to zero when no beat is shown.
  always_comb begin
    in_ready  = in_ready_s;
    out_valid = cur_valid_s;
    Y         = cur_valid_s ? sel_idx_s : '0;
    last      = cur_valid_s && cur_last_s;
    zero      = cur_valid_s && zero_word_s;
  end

endmodule

// File: tb/tb_onehot_stream_encoder.sv
module tb_onehot_stream_encoder;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, out_ready;
  logic [3:0] D;

  logic       ir_l, ov_l, last_l, zero_l;
  logic [1:0] y_l;
  logic       ir_m, ov_m, last_m, zero_m;
  logic [1:0] y_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  onehot_stream_encoder #(.LSB_FIRST(1)) u_dut_lsb (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(ir_l),
    .D(D), .out_valid(ov_l), .out_ready(out_ready), .Y(y_l), .last(last_l),
    .zero(zero_l)
  );

  onehot_stream_encoder #(.LSB_FIRST(0)) u_dut_msb (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(ir_m),
    .D(D), .out_valid(ov_m), .out_ready(out_ready), .Y(y_m), .last(last_m),
    .zero(zero_m)
  );

  typedef struct {
    logic       rst, en, iv;
    logic [3:0] d;
    logic       ordy;
    logic       e_ir, e_ov;
    logic [1:0] e_y, e_ym;
    logic       e_last, e_zero;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the pending beats of the current word as a list of
  // indices in emission order; -1 stands for a zero-word beat.
  int q_l[$];
  int q_m[$];

  function automatic vec_t mk(logic r, logic e, logic iv, logic [3:0] d, logic ordy,
                              logic ir, logic ov, logic [1:0] y, logic [1:0] ym,
                              logic lst, logic z);
    vec_t v;
    v.rst = r; v.en = e; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = ir; v.e_ov = ov; v.e_y = y; v.e_ym = ym; v.e_last = lst; v.e_zero = z;
    return v;
  endfunction

  function automatic logic [5:0] model_out(input int q[$], input logic ir);
    logic       ov, lst, z;
    logic [1:0] y;
    ov  = (q.size() > 0);
    y   = (ov && q[0] >= 0) ? 2'(q[0]) : 2'd0;
    lst = (q.size() == 1);
    z   = ov && (q[0] < 0);
    return {ir, ov, y, lst, z};
  endfunction

  task automatic run_cycle(input vec_t v, input logic chk_tbl, input string name);
    logic       m_ir;
    logic [5:0] exp_v, act_v;
    logic [6:0] t_exp, t_act;
    rst = v.rst; en = v.en; in_valid = v.iv; D = v.d; out_ready = v.ordy;
    @(negedge clk);
    m_ir = !rst && en && ((q_l.size() == 0) || (out_ready && q_l.size() == 1));
    // model check, ascending instance
    exp_v = model_out(q_l, m_ir);
    act_v = {ir_l, ov_l, y_l, last_l, zero_l};
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL model_lsb %s t=%0t got %b want %b", name, $time, act_v, exp_v);
    end
    // model check, descending instance
    exp_v = model_out(q_m, m_ir);
    act_v = {ir_m, ov_m, y_m, last_m, zero_m};
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL model_msb %s t=%0t got %b want %b", name, $time, act_v, exp_v);
    end
    if (chk_tbl) begin
      t_exp = {v.e_ir, v.e_ov, v.e_y, v.e_last, v.e_zero, v.e_ym[0]};
      t_act = {ir_l, ov_l, y_l, last_l, zero_l, y_m[0]};
      n_vec++;
      if (t_act !== t_exp || (v.e_ym !== y_m)) begin
        n_err++;
        $display("FAIL table %s t=%0t got ir/ov/y/last/zero=%b ym=%0d want %b ym=%0d",
                 name, $time, t_act[6:1], y_m, t_exp[6:1], v.e_ym);
      end
    end
    // advance model
    if (rst) begin
      q_l.delete();
      q_m.delete();
    end else begin
      if (q_l.size() > 0 && out_ready) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (in_valid && m_ir) begin
        for (int i = 0; i < 4; i++) begin
          if (D[i]) begin
            q_l.push_back(i);
            q_m.push_front(i);
          end
        end
`ifdef ONEHOT_STREAM_ENCODER_ZERO_FLAG_EN
        if (D == 4'd0) begin
          q_l.push_back(-1);
          q_m.push_back(-1);
        end
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic zf;
`ifdef ONEHOT_STREAM_ENCODER_ZERO_FLAG_EN
    zf = 1'b1;
`else
    zf = 1'b0;
`endif
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; D = 4'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    //            rst  en  iv  d        ordy  ir ov y     ym    last zero
    // reset state
    tbl.push_back(mk(1, 1, 0, 4'b0000, 1,    0, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    // single bit
    tbl.push_back(mk(0, 1, 1, 4'b0100, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 1, 2'd2, 2'd2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    // multi-hot, both orders
    tbl.push_back(mk(0, 1, 1, 4'b1011, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    0, 1, 2'd0, 2'd3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    0, 1, 2'd1, 2'd1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 1, 2'd3, 2'd0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    // backpressure
    tbl.push_back(mk(0, 1, 1, 4'b0110, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 0,    0, 1, 2'd1, 2'd2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 0,    0, 1, 2'd1, 2'd2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 0,    0, 1, 2'd1, 2'd2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    0, 1, 2'd1, 2'd2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 1, 2'd2, 2'd1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    // back-to-back
    tbl.push_back(mk(0, 1, 1, 4'b0001, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'b1000, 1,    1, 1, 2'd0, 2'd0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 1, 2'd3, 2'd3, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    // reset mid-word
    tbl.push_back(mk(0, 1, 1, 4'b1111, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    0, 1, 2'd0, 2'd3, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 1,    0, 1, 2'd1, 2'd2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    // enable gating
    tbl.push_back(mk(0, 1, 1, 4'b0011, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0100, 1,    0, 1, 2'd0, 2'd1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0100, 1,    0, 1, 2'd1, 2'd0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0100, 1,    0, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'b0100, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 1, 2'd2, 2'd2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    // zero word
    tbl.push_back(mk(0, 1, 1, 4'b0000, 1,    1, 0, 2'd0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, zf, 2'd0, 2'd0, zf, zf));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 1,    1, 0, 2'd0, 2'd0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i], 1'b1, $sformatf("row%0d", i));
    end

    // Hand sequence: final beat stalled blocks acceptance until released,
    // then the next word follows with no bubble.
    run_cycle(mk(0, 1, 1, 4'b0010, 1, 1, 0, 2'd0, 2'd0, 0, 0), 1'b1, "stall_acc");
    run_cycle(mk(0, 1, 1, 4'b0001, 0, 0, 1, 2'd1, 2'd1, 1, 0), 1'b1, "stall_last");
    run_cycle(mk(0, 1, 1, 4'b0001, 1, 1, 1, 2'd1, 2'd1, 1, 0), 1'b1, "stall_free");
    run_cycle(mk(0, 1, 0, 4'b0000, 1, 1, 1, 2'd0, 2'd0, 1, 0), 1'b1, "stall_next");
    run_cycle(mk(0, 1, 0, 4'b0000, 1, 1, 0, 2'd0, 2'd0, 0, 0), 1'b1, "stall_idle");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      v = mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) != 0), 0, 0, 2'd0, 2'd0, 0, 0);
      run_cycle(v, 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
